// File: rtl/div_ser_pkg.sv
// Shared types and frame constants for the divider-result UART serializer.
// DIV_SER_PARITY_EN selects the 8E1 frame (adds the PARITY state).
package div_ser_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

`ifdef DIV_SER_PARITY_EN
    localparam int FRAME_BITS = 1 + DATA_BITS + 1 + STOP_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } ser_state_t;
`else
    localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } ser_state_t;
`endif

endpackage

// File: rtl/div_ser_bit_timer.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module div_ser_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Wrapping on bit_done is the reload for every bit/state change inside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_done = (cnt == LAST);

endmodule

// File: rtl/div_result_serializer.sv
// Serializes packed divider results {quotient, remainder} as UART 8N1 frames,
// or 8E1 when DIV_SER_PARITY_EN is defined. One holding register allows back-to-back frames.
module div_result_serializer
    import div_ser_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic [7:0] res_data,
    output logic       res_ready,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // Handshake: a byte is accepted on a rising edge where res_valid && res_ready;
    // res_ready is simply "holding register empty" and never depends on res_valid.
    ser_state_t           state;
    ser_state_t           state_next;
    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_full;
    logic [DATA_BITS-1:0] shift;
    logic [2:0]           bit_idx;
    logic                 bit_done;
    logic                 restart;
    logic                 take;
    logic                 tx_next;
    logic                 accept;
`ifdef DIV_SER_PARITY_EN
    logic                 parity;
`endif

    assign res_ready = !hold_full;
    assign accept    = res_valid && res_ready;
    assign busy      = (state != IDLE) || hold_full;

    div_ser_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (hold_full) state_next = START;
            START: if (bit_done) state_next = DATA;
            DATA: begin
                if (bit_done && (bit_idx == LAST_BIT)) begin
`ifdef DIV_SER_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef DIV_SER_PARITY_EN
            PARITY: if (bit_done) state_next = STOP;
`endif
            STOP:  if (bit_done) state_next = hold_full ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        restart = 1'b0;
        take    = 1'b0;
        tx_next = 1'b1;
        case (state)
            IDLE: begin
                restart = 1'b1;
                take    = hold_full;
            end
            START:  tx_next = 1'b0;
            DATA:   tx_next = shift[0];
`ifdef DIV_SER_PARITY_EN
            PARITY: tx_next = parity;
`endif
            STOP:   take = bit_done && hold_full;
            default: tx_next = 1'b1;
        endcase
    end

    // tx is registered so the line is glitch-free; it trails the state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            bit_idx   <= '0;
            tx        <= 1'b1;
        end else begin
            if (accept) begin
                hold_data <= res_data;
            end
            hold_full <= accept || (hold_full && !take);
            if (take) begin
                shift   <= hold_data;
                bit_idx <= '0;
            end else if ((state == DATA) && bit_done) begin
                shift   <= {1'b0, shift[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            tx <= tx_next;
        end
    end

`ifdef DIV_SER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (take) begin
            parity <= ^hold_data;
        end
    end
`endif

endmodule

// File: tb/tb_div_result_serializer.sv
// Randomized bench for div_result_serializer with a line-level UART receiver model.
module tb_div_result_serializer;

    localparam int CPB    = 4;
    localparam int PERIOD = 10;
`ifdef DIV_SER_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready;
    logic       tx;
    logic       busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_sent  = 0;
    int         frames_rx = 0;
    bit         rx_en = 1'b0;
    logic [7:0] exp_q[$];
    longint     fall_q[$];
    longint     last_acc_t;

    div_result_serializer #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .tx        (tx),
        .busy      (busy)
    );

    always #(PERIOD / 2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] pack_div(input int a, input int b);
        logic [3:0] q;
        logic [3:0] r;
        q = 4'(a / b);
        r = 4'(a % b);
        return {q, r};
    endfunction

    // Offer a byte and hold it until accepted; records the accept edge time.
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        res_valid = 1'b1;
        res_data  = b;
        n = 0;
        while (!res_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!res_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            res_valid = 1'b0;
        end else begin
            last_acc_t = $time + PERIOD / 2;
            exp_q.push_back(b);
            n_sent++;
            @(posedge clk);
            #1;
            res_valid = 1'b0;
            res_data  = 8'($urandom);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("drain_timeout", 32'd0, 32'd1);
        repeat (CPB * 2) @(negedge clk);
    endtask

    // Receiver: each frame is NBITS bits of exactly CPB cycles; decode mid-bit.
    initial begin
        logic [FRAME_CYC-1:0] samp;
        logic [NBITS-1:0]     bitv;
        logic [7:0]           d;
        logic [7:0]           e;
        logic                 stable;
        forever begin
            @(negedge clk);
            if (rx_en && rst_n && tx === 1'b0) begin
                fall_q.push_back($time);
                samp[0] = tx;
                for (int i = 1; i < FRAME_CYC; i++) begin
                    @(negedge clk);
                    samp[i] = tx;
                end
                stable = 1'b1;
                for (int b = 0; b < NBITS; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (samp[b * CPB + c] !== samp[b * CPB]) stable = 1'b0;
                    end
                    bitv[b] = samp[b * CPB + CPB / 2];
                end
                for (int k = 0; k < 8; k++) d[k] = bitv[1 + k];
                check("bit_width", 32'(stable), 32'd1);
                check("start_bit", 32'(bitv[0]), 32'd0);
                check("stop_bit", 32'(bitv[NBITS-1]), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(d), 32'(e));
`ifdef DIV_SER_PARITY_EN
                    check("parity", 32'(bitv[9]), 32'(^e));
`endif
                end
                frames_rx++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int idx;
        rst_n     = 1'b0;
        res_valid = 1'b0;
        res_data  = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(res_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_tx", 32'(tx), 32'd1);

        // Reset in the middle of a frame: line snaps high, nothing resent.
        send_byte(8'h00);
        send_byte(8'hFF);
        repeat (12) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_tx_data", 32'(tx), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_ready", 32'(res_ready), 32'd1);
        exp_q.delete();
        n_sent = 0;
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (120) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("no_retransmit", 32'(lows), 32'd0);
        rx_en = 1'b1;

        // 100/7 -> 0xE2, latency from accept edge to tx falling.
        idx = fall_q.size();
        check("pack_100_7", 32'(pack_div(100, 7)), 32'hE2);
        send_byte(pack_div(100, 7));
        wait_drain();
        if (fall_q.size() > idx)
            check("start_latency", 32'((fall_q[idx] - last_acc_t - PERIOD / 2) / PERIOD), 32'd2);
        else
            check("start_latency_missing", 32'(fall_q.size()), 32'(idx + 1));

        // Back-to-back: 0xD5, 0x50, then a third held off while holding is full.
        idx = fall_q.size();
        send_byte(pack_div(200, 15));
        send_byte(pack_div(255, 3));
        @(negedge clk);
        check("ready_low_2nd", 32'(res_ready), 32'd0);
        check("busy_2nd", 32'(busy), 32'd1);
        send_byte(8'($urandom));
        wait_drain();
        if (fall_q.size() >= idx + 3) begin
            check("gap_1_2", 32'((fall_q[idx+1] - fall_q[idx]) / PERIOD), 32'(FRAME_CYC));
            check("gap_2_3", 32'((fall_q[idx+2] - fall_q[idx+1]) / PERIOD), 32'(FRAME_CYC));
        end else begin
            check("b2b_frames_missing", 32'(fall_q.size()), 32'(idx + 3));
        end

        // Edge bytes, also back-to-back.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h00);
        wait_drain();

        // Random bytes with random idle gaps (sometimes zero).
        for (int i = 0; i < 14; i++) begin
            repeat ($urandom_range(0, 45)) @(negedge clk);
            send_byte(8'($urandom));
        end
        wait_drain();

        check("frames_rx", 32'(frames_rx), 32'(n_sent));
        check("end_busy", 32'(busy), 32'd0);
        check("end_ready", 32'(res_ready), 32'd1);
        check("end_tx", 32'(tx), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
